// File: rtl/io_link_pkg.sv
// Shared types and helpers for the pin-side frame link: opcodes, link states and the command byte encoding.
package io_link_pkg;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_JUMP  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } link_state_t;

  localparam logic [3:0] CMD_TAG = 4'hA;

  function automatic logic [7:0] cmd_byte(input op_t op);
    return {CMD_TAG, 2'b00, op};
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level input.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr <= '0;
    else      sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/io_frame_link.sv
// Turns one bus request into a framed byte sequence on the 8-bit pins using a 4-phase strb/ack handshake.
module io_frame_link
  import io_link_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err,
  output logic [7:0]  pin_out,
  input  logic [7:0]  pin_in,
  output logic        strb,
  input  logic        ack
);

  localparam logic [7:0] TO_LIMIT = 8'(ACK_TIMEOUT - 1);
  localparam logic       P_HI     = 1'b0;
  localparam logic       P_LO     = 1'b1;

  link_state_t state, state_next;
  logic        phase;
  logic [1:0]  byte_cnt;
  logic [7:0]  wait_cnt;
  op_t         op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] cap_q;
  logic        err_q;
  logic        armed;
  logic        ack_s;
  logic        busy;
  logic        phase_done;
  logic        last_byte;
  logic        step;
  logic        timeout;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack),
    .q   (ack_s)
  );

  // A rise only counts once ack_s has been seen low, so a stale ack cannot complete the first strobe.
  assign busy       = (state == ST_CMD) || (state == ST_ADDR) ||
                      (state == ST_WDATA) || (state == ST_RDATA);
  assign phase_done = busy && ((phase == P_HI) ? (ack_s && armed) : !ack_s);
  assign last_byte  = (state == ST_CMD) || (byte_cnt == 2'd3);
  assign step       = phase_done && (phase == P_LO) && last_byte;
  assign timeout    = busy && !phase_done && (wait_cnt == TO_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (req_valid) state_next = ST_CMD;
      ST_CMD: begin
        if (timeout)   state_next = ST_DONE;
        else if (step) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        if (timeout)   state_next = ST_DONE;
        else if (step) state_next = (op_q == OP_STORE) ? ST_WDATA :
                                    (op_q == OP_JUMP)  ? ST_DONE  : ST_RDATA;
      end
      ST_WDATA, ST_RDATA: if (timeout || step) state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rvalid    = (state == ST_DONE);
    err       = (state == ST_DONE) && err_q;
    strb      = busy && (phase == P_HI);
    pin_out   = '0;
    unique case (state)
      ST_CMD:   pin_out = cmd_byte(op_q);
      ST_ADDR:  pin_out = addr_q[{byte_cnt, 3'b000} +: 8];
      ST_WDATA: pin_out = wdata_q[{byte_cnt, 3'b000} +: 8];
      default:  pin_out = '0;
    endcase
  end

  // Read bytes land in cap_q and only reach rdata when the whole frame completes without timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= P_HI;
      byte_cnt <= '0;
      wait_cnt <= '0;
      op_q     <= OP_FETCH;
      addr_q   <= '0;
      wdata_q  <= '0;
      cap_q    <= '0;
      rdata    <= '0;
      err_q    <= 1'b0;
      armed    <= 1'b0;
    end else begin
      armed <= (state == ST_IDLE) ? !ack_s : (armed || !ack_s);
      if ((state == ST_IDLE) && req_valid) begin
        op_q     <= op_t'(req_op);
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        cap_q    <= rdata;
        err_q    <= 1'b0;
        phase    <= P_HI;
        byte_cnt <= '0;
        wait_cnt <= '0;
      end else if (busy) begin
        if (timeout) begin
          err_q    <= 1'b1;
          phase    <= P_HI;
          byte_cnt <= '0;
          wait_cnt <= '0;
        end else if (phase_done) begin
          wait_cnt <= '0;
          if (phase == P_HI) begin
            phase <= P_LO;
            if (state == ST_RDATA) cap_q[{byte_cnt, 3'b000} +: 8] <= pin_in;
          end else begin
            phase    <= P_HI;
            byte_cnt <= last_byte ? 2'd0 : byte_cnt + 2'd1;
            if ((state == ST_RDATA) && last_byte) rdata <= cap_q;
          end
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_frame_link.sv
// Randomized bench for io_frame_link with a responding host and a frame-level reference model.
module tb_io_frame_link;

  localparam int TO = 16;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic [7:0]  pin_out;
  logic [7:0]  pin_in = 8'd0;
  logic        strb;
  logic        ack = 1'b0;

  io_frame_link #(.ACK_TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .err       (err),
    .pin_out   (pin_out),
    .pin_in    (pin_in),
    .strb      (strb),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Frame-level model state
  int          cyc = 0;
  logic        frame_active = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  logic [7:0]  lit[$];
  logic        cur_read = 1'b0;
  logic [31:0] pend_rdata = 32'd0;
  logic [31:0] model_rdata = 32'd0;
  logic [31:0] force_rd = 32'd0;
  logic        force_rd_v = 1'b0;
  int          noack_idx = -1;
  int          next_noack = -1;
  int          hidx = 0;
  int          frames_done = 0;
  int          rv_count = 0;
  int          to_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Accept: build the expected byte stream straight from the request fields
  initial forever begin
    @(posedge clk);
    if (rst && req_valid && req_ready) begin
      exp_q.delete();
      obs_q.delete();
      exp_q.push_back({4'hA, 2'b00, req_op});
      for (int k = 0; k < 4; k++) exp_q.push_back(req_addr[8*k +: 8]);
      if (req_op == 2'd2) for (int k = 0; k < 4; k++) exp_q.push_back(req_wdata[8*k +: 8]);
      else if (req_op < 2'd2) for (int k = 0; k < 4; k++) exp_q.push_back(8'h00);
      cur_read   = (req_op < 2'd2);
      pend_rdata = force_rd_v ? force_rd : $urandom;
      force_rd_v = 1'b0;
      noack_idx  = next_noack;
      next_noack = -1;
      hidx       = 0;
      frame_active = 1'b1;
    end
  end

  // Host responder: random ack delays, returns read bytes LSB first
  initial begin
    int hs;
    int d;
    int hb;
    hs = 0; d = 0; hb = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ack = 1'b0;
        hs = 0;
      end else begin
        case (hs)
          0: if (strb) begin
            obs_q.push_back(pin_out);
            if (hidx < exp_q.size()) chk("frame_byte", 32'(pin_out), 32'(exp_q[hidx]));
            else chk("extra_strobe", hidx, exp_q.size());
            hb = hidx;
            hidx++;
            if (hb == noack_idx) begin
              hs = 3;
              to_cyc = cyc;
            end else begin
              d = $urandom_range(0, 4);
              hs = 1;
            end
          end
          1: if (d == 0) begin
            if (cur_read && hb >= 5) pin_in = pend_rdata[8*(hb-5) +: 8];
            ack = 1'b1;
            hs = 2;
          end else d--;
          2: if (!strb) begin
            pin_in = 8'($urandom);
            d = $urandom_range(0, 4);
            hs = 4;
          end
          4: if (d == 0) begin
            ack = 1'b0;
            hs = 0;
          end else d--;
          3: if (!strb) hs = 0;
          default: hs = 0;
        endcase
      end
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("req_ready", 32'(req_ready), 32'(!frame_active));
      if (!frame_active) chk("strb_idle", 32'(strb), 32'd0);
      if (rvalid) begin
        rv_count++;
        chk("rvalid_in_frame", 32'(frame_active), 32'd1);
        chk("err", 32'(err), 32'(noack_idx >= 0));
        chk("strb_done", 32'(strb), 32'd0);
        chk("strobes", hidx, (noack_idx >= 0) ? noack_idx + 1 : exp_q.size());
        if (noack_idx >= 0)
          chk("timeout_window", 32'((cyc - to_cyc >= TO - 1) && (cyc - to_cyc <= TO + 1)), 32'd1);
        if (cur_read && noack_idx < 0) model_rdata = pend_rdata;
        frame_active = 1'b0;
        frames_done++;
      end else begin
        chk("err_idle", 32'(err), 32'd0);
      end
      chk("rdata", rdata, model_rdata);
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("frame_end", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] w);
    int f0;
    f0 = frames_done;
    wait_ready();
    req_op = op;
    req_addr = a;
    req_wdata = w;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_frames(f0 + 1);
  endtask

  task automatic check_obs(input string name);
    chk({name, "_len"}, obs_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < obs_q.size(); i++)
      chk(name, 32'(obs_q[i]), 32'(lit[i]));
  endtask

  initial begin
    int rv0;
    int f0;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_strb", 32'(strb), 32'd0);
    chk("rst_pin_out", 32'(pin_out), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // FETCH, host returns 04 00 22 8C
    rv0 = rv_count;
    force_rd = 32'h8C22_0004; force_rd_v = 1'b1;
    run(2'd0, 32'h0000_0040, 32'd0);
    repeat (3) @(negedge clk);
    lit = '{8'hA0, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_obs("fetch_bytes");
    chk("fetch_rdata", rdata, 32'h8C22_0004);
    chk("fetch_rvalid_cnt", rv_count - rv0, 1);

    // STORE
    rv0 = rv_count;
    run(2'd2, 32'h0000_0010, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    lit = '{8'hA2, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    check_obs("store_bytes");
    chk("store_rdata", rdata, 32'h8C22_0004);
    chk("store_rvalid_cnt", rv_count - rv0, 1);

    // JUMP, preceded by a stale ack held high while idle
    ack = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_ack_strb", 32'(strb), 32'd0);
    ack = 1'b0;
    run(2'd3, 32'h0040_0000, 32'd0);
    lit = '{8'hA3, 8'h00, 8'h00, 8'h40, 8'h00};
    check_obs("jump_bytes");

    // Timeout on the third address byte
    next_noack = 3;
    run(2'd0, 32'h0000_0100, 32'd0);
    lit = '{8'hA0, 8'h00, 8'h01, 8'h00};
    check_obs("timeout_bytes");
    chk("timeout_rdata", rdata, 32'h8C22_0004);

    // Asynchronous reset in the middle of WDATA byte 2
    wait_ready();
    req_op = 2'd2; req_addr = 32'h20; req_wdata = 32'h1122_3344; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (hidx < 8 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wdata2", 32'(hidx >= 8), 32'd1);
    #2 rst = 1'b0;
    model_rdata = 32'd0;
    frame_active = 1'b0;
    #1;
    chk("arst_strb", 32'(strb), 32'd0);
    chk("arst_pin_out", 32'(pin_out), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    force_rd = 32'hCAFE_F00D; force_rd_v = 1'b1;
    run(2'd1, 32'h0000_0080, 32'd0);
    lit = '{8'hA1, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_obs("load_bytes");
    chk("load_rdata", rdata, 32'hCAFE_F00D);

    // req_valid held high across two frames
    f0 = frames_done;
    wait_ready();
    req_op = 2'd1; req_addr = 32'h0000_1234; req_valid = 1'b1;
    n = 0;
    while (frames_done < f0 + 2 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("held_frames", frames_done - f0, 2);
    repeat (3) @(negedge clk);

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      run(2'($urandom_range(0, 3)), $urandom, $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, limit 500000", $time);
    $fatal(1, "watchdog");
  end

endmodule
